opcode_processor_pipe: RTL and testbench

Parametrised, pipelined successor to the 4-bit-opcode/8-bit-data opcode processor. Executes a stream of opcode/data commands against an internal accumulator. Adds a valid/ready handshake on both sides, a selectable saturating arithmetic mode, status flags and an executed-op counter. Sits between a command source (bench driver or sequencer) and a result consumer; a single instance serves one command stream.

---
 rtl/opcode_processor_pipe.sv | 191 +++++++++++++++++++
 tb/tb_opcode_processor_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opcode_processor_pipe.sv
// opcode_processor_pipe
//
// Two-stage pipelined opcode processor. It takes a stream of opcode/data
// commands and runs each one against an internal accumulator. For every
// command it returns the result, a set of status flags and a running count
// of executed commands.
//
// Stages:
//   S1 - input register that holds the accepted command.
//   S2 - execute/output register that holds the result, the flags and
//        out_valid.
//
// Parameters:
//   DATA_W - width of data, accumulator and result (>= 4)
//   SAT_EN - 1: ADD/SUB/INC/DEC clamp on overflow/underflow; 0: wrap
//   CNT_W  - width of op_count
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  command handshake
//   opcode, data       command fields
//   out_valid/out_ready result handshake
//   result             accumulator after the op (CMP: acc - data)
//   flag_z/c/v/err     zero, carry/borrow/shift-out, saturation, illegal op
//   op_count           commands executed since reset; holds at all-ones
//
// Handshake: a transfer happens on any rising edge where valid && ready.
// A source may not retract valid or change its payload until the transfer.
// Ready never depends on the same side's valid.
module opcode_processor_pipe #(
  parameter int DATA_W = 8,
  parameter int SAT_EN = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v,
  output logic              flag_err,
  output logic [CNT_W-1:0]  op_count
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_INC  = 4'd10;
  localparam logic [3:0] OP_DEC  = 4'd11;
  localparam logic [3:0] OP_CLR  = 4'd12;
  localparam logic [3:0] OP_CMP  = 4'd13;

  localparam logic [DATA_W-1:0] ONE     = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // rdy_q keeps in_ready low while reset is asserted. It rises on the
  // first clock edge after reset is released.
  logic              rdy_q;
  logic              s1_valid;
  logic [3:0]        s1_op;
  logic [DATA_W-1:0] s1_data;
  logic [DATA_W-1:0] acc;
  logic              advance;

  assign advance  = s1_valid && (!out_valid || out_ready);
  assign in_ready = rdy_q && (!s1_valid || advance);

  // Execute logic for the command sitting in S1
  logic [SH_W-1:0]   amt;
  logic [DATA_W-1:0] operand;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   dif;
  logic [DATA_W:0]   shl_w;
  logic [DATA_W:0]   shr_w;
  logic [DATA_W-1:0] nxt_acc;
  logic [DATA_W-1:0] nxt_res;
  logic              nxt_c;
  logic              nxt_v;
  logic              nxt_err;

  always_comb begin
    amt     = s1_data[SH_W-1:0];
    operand = (s1_op == OP_INC || s1_op == OP_DEC) ? ONE : s1_data;
    // The extra MSB of sum/dif is the carry or borrow out.
    sum     = {1'b0, acc} + {1'b0, operand};
    dif     = {1'b0, acc} - {1'b0, operand};
    // A one-bit guard catches the last bit shifted out: it sits above the
    // MSB for SHL and below the LSB for SHR. It stays 0 when amt is 0.
    shl_w   = {1'b0, acc} << amt;
    shr_w   = {acc, 1'b0} >> amt;
    nxt_acc = acc;
    nxt_c   = 1'b0;
    nxt_v   = 1'b0;
    nxt_err = 1'b0;
    case (s1_op)
      OP_NOP:  nxt_acc = acc;
      OP_LOAD: nxt_acc = s1_data;
      OP_ADD, OP_INC: begin
        nxt_c = sum[DATA_W];
        if (SAT_EN != 0 && sum[DATA_W]) begin
          nxt_acc = '1;
          nxt_v   = 1'b1;
        end else begin
          nxt_acc = sum[DATA_W-1:0];
        end
      end
      OP_SUB, OP_DEC: begin
        nxt_c = dif[DATA_W];
        if (SAT_EN != 0 && dif[DATA_W]) begin
          nxt_acc = '0;
          nxt_v   = 1'b1;
        end else begin
          nxt_acc = dif[DATA_W-1:0];
        end
      end
      OP_AND:  nxt_acc = acc & s1_data;
      OP_OR:   nxt_acc = acc | s1_data;
      OP_XOR:  nxt_acc = acc ^ s1_data;
      OP_NOT:  nxt_acc = ~acc;
      OP_SHL: begin
        nxt_acc = shl_w[DATA_W-1:0];
        nxt_c   = shl_w[DATA_W];
      end
      OP_SHR: begin
        nxt_acc = shr_w[DATA_W:1];
        nxt_c   = shr_w[0];
      end
      OP_CLR:  nxt_acc = '0;
      OP_CMP:  nxt_c = dif[DATA_W];
      default: nxt_err = 1'b1;
    endcase
    // CMP reports the difference but leaves acc alone. It never saturates.
    nxt_res = (s1_op == OP_CMP) ? dif[DATA_W-1:0] : nxt_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_data   <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      flag_err  <= 1'b0;
      op_count  <= '0;
    end else begin
      rdy_q <= 1'b1;

      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_op    <= opcode;
        s1_data  <= data;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end

      if (advance) begin
        acc       <= nxt_acc;
        result    <= nxt_res;
        flag_z    <= (nxt_res == '0);
        flag_c    <= nxt_c;
        flag_v    <= nxt_v;
        flag_err  <= nxt_err;
        out_valid <= 1'b1;
        if (op_count != '1) op_count <= op_count + CNT_ONE;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_opcode_processor_pipe.sv
// Testbench for opcode_processor_pipe.
// It runs a wrapping instance (SAT_EN=0) and a saturating instance
// (SAT_EN=1) side by side on the same command stream. Both use a 4-bit
// op counter so that counter saturation is reached quickly.
module tb_opcode_processor_pipe;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam int CNT_MAX = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic [3:0]    opcode = '0;
  logic [DW-1:0] data = '0;
  logic          out_ready = 1'b0;

  logic          ir  [2];
  logic          ov  [2];
  logic [DW-1:0] res [2];
  logic          fz  [2];
  logic          fc  [2];
  logic          fv  [2];
  logic          fe  [2];
  logic [CW-1:0] cnt [2];

  opcode_processor_pipe #(.DATA_W(DW), .SAT_EN(0), .CNT_W(CW)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .opcode(opcode), .data(data), .out_valid(ov[0]), .out_ready(out_ready),
    .result(res[0]), .flag_z(fz[0]), .flag_c(fc[0]), .flag_v(fv[0]),
    .flag_err(fe[0]), .op_count(cnt[0]));

  opcode_processor_pipe #(.DATA_W(DW), .SAT_EN(1), .CNT_W(CW)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .opcode(opcode), .data(data), .out_valid(ov[1]), .out_ready(out_ready),
    .result(res[1]), .flag_z(fz[1]), .flag_c(fc[1]), .flag_v(fv[1]),
    .flag_err(fe[1]), .op_count(cnt[1]));

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int inst, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] got=0x%0h want=0x%0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] res;
    logic z, c, v, e;
  } out_t;

  typedef struct packed {
    out_t wr;
    out_t st;
  } exp_t;

  exp_t exp_q[$];

  // Reference semantics of one op, using plain integer arithmetic
  function automatic out_t exec(input bit sat, input logic [3:0] op,
                                input logic [DW-1:0] a, input logic [DW-1:0] d,
                                output logic [DW-1:0] na);
    out_t o;
    int ai, di, s, n, r;
    ai = int'(a); di = int'(d); n = di % DW;
    o = '0; r = ai;
    case (op)
      4'd0: r = ai;
      4'd1: r = di;
      4'd2, 4'd10: begin
        s = ai + ((op == 4'd2) ? di : 1);
        if (s > 255) begin o.c = 1; if (sat) begin r = 255; o.v = 1; end else r = s - 256; end
        else r = s;
      end
      4'd3, 4'd11: begin
        s = ai - ((op == 4'd3) ? di : 1);
        if (s < 0) begin o.c = 1; if (sat) begin r = 0; o.v = 1; end else r = s + 256; end
        else r = s;
      end
      4'd4: r = ai & di;
      4'd5: r = ai | di;
      4'd6: r = ai ^ di;
      4'd7: r = 255 - ai;
      4'd8: begin r = (ai << n) & 255; o.c = (n == 0) ? 1'b0 : 1'((ai >> (8 - n)) & 1); end
      4'd9: begin r = ai >> n;         o.c = (n == 0) ? 1'b0 : 1'((ai >> (n - 1)) & 1); end
      4'd12: r = 0;
      4'd13: r = ai;
      default: begin r = ai; o.e = 1; end
    endcase
    na = 8'(r);
    if (op == 4'd13) begin
      s = ai - di;
      o.c = (s < 0);
      o.res = 8'((s + 256) % 256);
    end else begin
      o.res = 8'(r);
    end
    o.z = (o.res == 0);
    return o;
  endfunction

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_acc_w = '0;
  logic [DW-1:0] m_acc_s = '0;
  bit m_ov = 0;
  bit m_rdy = 0;
  int m_cnt = 0;
  bit run_chk = 0;

  // S1 holds a command whenever more commands are in flight than are
  // currently presented on the output.
  function automatic bit m_s1();
    return exp_q.size() > (m_ov ? 1 : 0);
  endfunction

  function automatic bit m_in_ready();
    return m_rdy && (!m_s1() || !m_ov || out_ready);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_q.delete();
      m_ov = 0; m_rdy = 0; m_cnt = 0; m_acc_w = '0; m_acc_s = '0;
    end else begin
      bit s1, adv, take, pop, ov_n;
      exp_t e;
      logic [DW-1:0] nw, ns;
      s1   = m_s1();
      adv  = s1 && (!m_ov || out_ready);
      take = in_valid && m_in_ready();
      pop  = m_ov && out_ready;
      ov_n = adv || (m_ov && !out_ready);
      if (pop) void'(exp_q.pop_front());
      if (adv && m_cnt < CNT_MAX) m_cnt++;
      if (take) begin
        e.wr = exec(1'b0, opcode, m_acc_w, data, nw);
        e.st = exec(1'b1, opcode, m_acc_s, data, ns);
        m_acc_w = nw; m_acc_s = ns;
        exp_q.push_back(e);
      end
      m_ov = ov_n;
      m_rdy = 1;
    end
  end

  // compare process: checks the DUT against the model every cycle
  initial forever begin
    @(negedge clk);
    if (rst_n && run_chk) begin
      for (int i = 0; i < 2; i++) begin
        out_t o;
        chk("in_ready", i, int'(ir[i]), int'(m_in_ready()));
        chk("out_valid", i, int'(ov[i]), int'(m_ov));
        chk("op_count", i, int'(cnt[i]), m_cnt);
        if (m_ov && exp_q.size() > 0) begin
          o = (i == 0) ? exp_q[0].wr : exp_q[0].st;
          chk("result", i, int'(res[i]), int'(o.res));
          chk("flag_z", i, int'(fz[i]), int'(o.z));
          chk("flag_c", i, int'(fc[i]), int'(o.c));
          chk("flag_v", i, int'(fv[i]), int'(o.v));
          chk("flag_err", i, int'(fe[i]), int'(o.e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int rd_mode = 0; // 0: out_ready=1, 1: random, 2: held low

  initial forever begin
    @(posedge clk); #2;
    case (rd_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 9) < 7);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send(input logic [3:0] op, input logic [DW-1:0] d);
    bit got = 0;
    int n = 0;
    in_valid = 1'b1; opcode = op; data = d;
    while (!got) begin
      @(negedge clk); got = ir[0];
      @(posedge clk); #1;
      n++;
      if (!got && n > 200) begin
        chk("send_timeout", 0, 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    rd_mode = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && !m_ov) done = 1;
    end
    #1;
    if (!done) chk("drain_timeout", 0, 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_valid", i, int'(ov[i]), 0);
      chk("rst_result", i, int'(res[i]), 0);
      chk("rst_flags", i, int'({fz[i], fc[i], fv[i], fe[i]}), 0);
      chk("rst_op_count", i, int'(cnt[i]), 0);
      chk("rst_in_ready", i, int'(ir[i]), 0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] na;
    out_t o;

    // Hand-computed values that anchor the reference model
    o = exec(1'b0, 4'd2, 8'h80, 8'hFF, na);
    chk("pin_add_wrap", 0, int'({o.res, o.c, o.v}), int'({8'h7F, 1'b1, 1'b0}));
    o = exec(1'b1, 4'd2, 8'h80, 8'hFF, na);
    chk("pin_add_sat", 1, int'({o.res, o.c, o.v}), int'({8'hFF, 1'b1, 1'b1}));
    o = exec(1'b1, 4'd11, 8'h00, 8'h00, na);
    chk("pin_dec_sat", 1, int'({o.res, o.c, o.v}), int'({8'h00, 1'b1, 1'b1}));
    o = exec(1'b0, 4'd8, 8'h81, 8'h01, na);
    chk("pin_shl", 0, int'({o.res, o.c}), int'({8'h02, 1'b1}));
    o = exec(1'b0, 4'd9, 8'h02, 8'h04, na);
    chk("pin_shr", 0, int'({o.res, o.c, o.z}), int'({8'h00, 1'b0, 1'b1}));
    o = exec(1'b1, 4'd13, 8'h00, 8'h02, na);
    chk("pin_cmp", 1, int'({o.res, o.c, o.v, na}), int'({8'hFE, 1'b1, 1'b0, 8'h00}));
    o = exec(1'b0, 4'd14, 8'h55, 8'h00, na);
    chk("pin_illegal", 0, int'({o.res, o.e, na}), int'({8'h55, 1'b1, 8'h55}));

    do_reset();
    run_chk = 1;

    // Plan 1/2: LOAD 7F, ADD 01, ADD FF, then SUB FF, DEC
    rd_mode = 0;
    send(4'd1, 8'h7F); send(4'd2, 8'h01); send(4'd2, 8'hFF);
    drain();
    chk("op_count_after3", 0, int'(cnt[0]), 3);
    send(4'd3, 8'hFF); send(4'd11, 8'h00);
    drain();

    // Plan 3: shifts and compare
    send(4'd1, 8'h81); send(4'd8, 8'h01); send(4'd9, 8'h04); send(4'd13, 8'h02);
    drain();

    // Plan 4: backpressure for 5 cycles
    rd_mode = 2;
    @(posedge clk); @(posedge clk); #1;
    send(4'd1, 8'h10); send(4'd10, 8'h00);
    fork
      begin
        @(negedge clk);
        chk("bp_in_ready", 0, int'(ir[0]), 0);
        chk("bp_out_valid", 0, int'(ov[0]), 1);
        repeat (4) @(posedge clk);
        rd_mode = 0;
      end
    join_none
    send(4'd2, 8'h05); send(4'd6, 8'hFF);
    drain();

    // Plan 5: illegal opcode after LOAD
    send(4'd1, 8'h55); send(4'd14, 8'h00); send(4'd2, 8'h01); send(4'd15, 8'h33);
    drain();

    // Plan 6: reset with S1 full and out_valid high
    rd_mode = 2;
    @(posedge clk); @(posedge clk); #1;
    send(4'd1, 8'h44); send(4'd2, 8'h11);
    #3;
    do_reset();
    send(4'd2, 8'h03);
    drain();

    // Random stream with random backpressure
    rd_mode = 1;
    for (int k = 0; k < 300; k++) begin
      send(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    chk("op_count_sat", 0, int'(cnt[0]), CNT_MAX);

    // ---------------- final report ----------------
    run_chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
